// File: rtl/register_bank_arbiter_pkg.sv
// Shared encodings for the register bank arbiter: command opcodes and FSM states.
package register_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXEC    = 2'b01,
    ST_MOVE_WR = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

endpackage

// File: rtl/register_bank_arbiter_if.sv
// Requester-side command/response bus plus the register bank pins.
interface register_bank_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
);
  logic [1:0]              req;
  logic [3:0]              op;
  logic [2*SEL_WIDTH-1:0]  rx_sel;
  logic [2*SEL_WIDTH-1:0]  ry_sel;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rdata_x;
  logic [DATA_WIDTH-1:0]   rdata_y;
  logic                    bank_write_en;
  logic                    bank_read_en;
  logic [SEL_WIDTH-1:0]    bank_rx_sel;
  logic [SEL_WIDTH-1:0]    bank_ry_sel;
  logic [DATA_WIDTH-1:0]   bank_wdata;
  logic [DATA_WIDTH-1:0]   bank_rx_data;
  logic [DATA_WIDTH-1:0]   bank_ry_data;

  modport slave (
    input  req, op, rx_sel, ry_sel, wdata, bank_rx_data, bank_ry_data,
    output ack, err, rdata_x, rdata_y,
    output bank_write_en, bank_read_en, bank_rx_sel, bank_ry_sel, bank_wdata
  );

  modport master (
    output req, op, rx_sel, ry_sel, wdata, bank_rx_data, bank_ry_data,
    input  ack, err, rdata_x, rdata_y,
    input  bank_write_en, bank_read_en, bank_rx_sel, bank_ry_sel, bank_wdata
  );
endinterface

// File: rtl/register_bank_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a contested request goes to the requester
// that did not win last time (the one not named by ptr).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~ptr;
      default: gnt_id = 1'b0;
    endcase
  end
endmodule

// File: rtl/register_bank_arbiter.sv
// Arbitrates two requesters onto one 8-entry register bank and sequences
// READ / WRITE / two-phase MOVE commands onto the bank pins.
//   state      | meaning
//   ST_IDLE    | waiting for req; latch winner's command
//   ST_EXEC    | selectors on bank; read capture or write strobe
//   ST_MOVE_WR | write MOVE temp into rx
//   ST_RESP    | one-cycle ack to the winner
module register_bank_arbiter
  import register_bank_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input logic                     clk,
  input logic                     reset,
  register_bank_arbiter_if.slave  bus
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic                  ptr_q, ptr_d;
  logic                  win_q, win_d;
  logic                  err_q, err_d;
  logic [SEL_WIDTH-1:0]  rx_q, rx_d, ry_q, ry_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d, tmp_q, tmp_d, rdx_q, rdx_d, rdy_q, rdy_d;
  logic                  gnt_valid, gnt_id;

  rr_arbiter2 u_rr_arbiter2 (
    .req       (bus.req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      wd_q    <= '0;
      tmp_q   <= '0;
      rdx_q   <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      wd_q    <= wd_d;
      tmp_q   <= tmp_d;
      rdx_q   <= rdx_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    err_d   = err_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    wd_d    = wd_q;
    tmp_d   = tmp_q;
    rdx_d   = rdx_q;
    rdy_d   = rdy_q;

    bus.ack           = 2'b00;
    bus.err           = err_q;
    bus.rdata_x       = rdx_q;
    bus.rdata_y       = rdy_q;
    bus.bank_write_en = 1'b0;
    bus.bank_read_en  = 1'b0;
    bus.bank_rx_sel   = '0;
    bus.bank_ry_sel   = '0;
    bus.bank_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          win_d   = gnt_id;
          ptr_d   = gnt_id;
          op_d    = op_e'(gnt_id ? bus.op[3:2] : bus.op[1:0]);
          rx_d    = gnt_id ? bus.rx_sel[2*SEL_WIDTH-1:SEL_WIDTH] : bus.rx_sel[SEL_WIDTH-1:0];
          ry_d    = gnt_id ? bus.ry_sel[2*SEL_WIDTH-1:SEL_WIDTH] : bus.ry_sel[SEL_WIDTH-1:0];
          wd_d    = gnt_id ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.wdata[DATA_WIDTH-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // A reserved op leaves the bank completely untouched.
        if (op_q != OP_RSVD) begin
          bus.bank_read_en = 1'b1;
          bus.bank_rx_sel  = rx_q;
          bus.bank_ry_sel  = ry_q;
        end
        state_d = ST_RESP;
        case (op_q)
          OP_READ: begin
            rdx_d = bus.bank_rx_data;
            rdy_d = bus.bank_ry_data;
          end
          OP_WRITE: begin
            bus.bank_write_en = 1'b1;
            bus.bank_wdata    = wd_q;
          end
          OP_MOVE: begin
            tmp_d   = bus.bank_ry_data;
            state_d = ST_MOVE_WR;
          end
          default: err_d = 1'b1;
        endcase
      end
      ST_MOVE_WR: begin
        bus.bank_write_en = 1'b1;
        bus.bank_rx_sel   = rx_q;
        bus.bank_wdata    = tmp_q;
        state_d           = ST_RESP;
      end
      ST_RESP: begin
        bus.ack = win_q ? 2'b10 : 2'b01;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
